// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: register-bus initiator that drives the peripheral side of
// uart_core. It programs CTRL and RX_EN after reset, sends queued TX bytes
// with the TX_EN handshake, and copies received bytes into a valid/ready
// output register.
// Optional build macro: UART_HOST_TX_TIMEOUT_EN adds a TX_WAIT watchdog that
// drives tx_err_o. When it is undefined, tx_err_o is tied low.
module uart_host_ctrl #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd87,
  parameter int unsigned TX_DEPTH     = 4,
  parameter logic [31:0] TX_TIMEOUT   = 32'd1200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        rx_overrun_o,
  output logic        tx_err_o,
  output logic        busy_o,
  output logic        bus_ren_o,
  output logic        bus_we_o,
  output logic [7:0]  bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        intr_tx_i
);
  localparam int unsigned    PTR_W    = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(TX_DEPTH);
  localparam logic [7:0]     A_CTRL   = 8'd0;
  localparam logic [7:0]     A_TXDATA = 8'd4;
  localparam logic [7:0]     A_RXDATA = 8'd8;
  localparam logic [7:0]     A_RXEN   = 8'd12;
  localparam logic [7:0]     A_TXEN   = 8'd16;
  localparam logic [7:0]     A_RXSTAT = 8'd20;

  typedef enum logic [3:0] {
    S_INIT_CTRL, S_INIT_RXEN, S_IDLE, S_RX_READ, S_TX_LOAD,
    S_TX_START, S_TX_WAIT, S_TX_RXRD, S_TX_STOP
  } state_t;

  state_t           state_q, state_d;
  logic             tx_done_q;
  logic [7:0]       fifo_mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push, pop;
  logic             rx_cap, rx_load;
  logic             rx_valid_q, rx_ovr_q;
  logic [7:0]       rx_data_q;
  logic             tmo_hit;
  logic             unused_rdata;

  assign unused_rdata = ^bus_rdata_i[31:8];

`ifdef UART_HOST_TX_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        tx_err_q;

  assign tmo_hit = (state_q == S_TX_WAIT) && !bus_rdata_i[0] && !intr_tx_i &&
                   (tmo_cnt_q >= TX_TIMEOUT - 32'd1);

  // Watchdog: restart on entry to TX_WAIT, count TX_WAIT cycles, latch the error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      tx_err_q  <= 1'b0;
    end else begin
      if (state_q == S_TX_START) tmo_cnt_q <= '0;
      else if (state_q == S_TX_WAIT) tmo_cnt_q <= tmo_cnt_q + 32'd1;
      if (tmo_hit) tx_err_q <= 1'b1;
    end
  end

  assign tx_err_o = tx_err_q;
`else
  assign tmo_hit  = 1'b0;
  assign tx_err_o = 1'b0;
`endif

  // State register; tx_done_q remembers a TX-done pulse that arrived while an RX read preempted TX_WAIT
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_INIT_CTRL;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_done_q <= (state_q == S_TX_WAIT) && intr_tx_i;
    end
  end

  // Next-state decode; a pending RX byte always wins over TX work
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT_CTRL: state_d = S_INIT_RXEN;
      S_INIT_RXEN: state_d = S_IDLE;
      S_IDLE: begin
        if (bus_rdata_i[0])     state_d = S_RX_READ;
        else if (count_q != '0) state_d = S_TX_LOAD;
      end
      S_RX_READ:  state_d = S_IDLE;
      S_TX_LOAD:  state_d = S_TX_START;
      S_TX_START: state_d = S_TX_WAIT;
      S_TX_WAIT: begin
        if (bus_rdata_i[0]) state_d = S_TX_RXRD;
        else if (intr_tx_i) state_d = S_TX_STOP;
        else if (tmo_hit)   state_d = S_TX_STOP;
      end
      S_TX_RXRD: state_d = (intr_tx_i || tx_done_q) ? S_TX_STOP : S_TX_WAIT;
      S_TX_STOP: state_d = S_IDLE;
      default:   state_d = S_INIT_CTRL;
    endcase
  end

  // Bus drive: idle-read of RX_STATUS unless the state issues a write or reads RX data
  always_comb begin
    bus_we_o    = 1'b0;
    bus_ren_o   = 1'b1;
    bus_addr_o  = A_RXSTAT;
    bus_wdata_o = '0;
    unique case (state_q)
      S_INIT_CTRL: begin
        bus_we_o = 1'b1; bus_ren_o = 1'b0; bus_addr_o = A_CTRL;
        bus_wdata_o = {16'd0, CLKS_PER_BIT};
      end
      S_INIT_RXEN: begin
        bus_we_o = 1'b1; bus_ren_o = 1'b0; bus_addr_o = A_RXEN; bus_wdata_o = 32'd1;
      end
      S_TX_LOAD: begin
        bus_we_o = 1'b1; bus_ren_o = 1'b0; bus_addr_o = A_TXDATA;
        bus_wdata_o = {24'd0, fifo_mem[rd_ptr_q]};
      end
      S_TX_START: begin
        bus_we_o = 1'b1; bus_ren_o = 1'b0; bus_addr_o = A_TXEN; bus_wdata_o = 32'd1;
      end
      S_TX_STOP: begin
        bus_we_o = 1'b1; bus_ren_o = 1'b0; bus_addr_o = A_TXEN; bus_wdata_o = 32'd0;
      end
      S_RX_READ, S_TX_RXRD: bus_addr_o = A_RXDATA;
      default: ;
    endcase
    // Keep the core untouched while reset is held; init writes start once it drops
    if (rst_i) begin
      bus_we_o    = 1'b0;
      bus_ren_o   = 1'b0;
      bus_addr_o  = '0;
      bus_wdata_o = '0;
    end
  end

  assign tx_ready_o = !rst_i && (count_q < DEPTH_C);
  assign push       = tx_valid_i && tx_ready_o;
  assign pop        = (state_q == S_TX_LOAD);
  assign busy_o     = (state_q != S_IDLE) || (count_q != '0);

  // TX FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= tx_data_i;
  end

  assign rx_cap  = (state_q == S_RX_READ) || (state_q == S_TX_RXRD);
  assign rx_load = rx_cap && (!rx_valid_q || rx_ready_i);

  // RX output handshake: load a captured byte, drop it with overrun if still occupied
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      if (rx_load)                      rx_valid_q <= 1'b1;
      else if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
      if (rx_cap && !rx_load)           rx_ovr_q   <= 1'b1;
    end
  end

  // RX data register
  always_ff @(posedge clk_i) begin
    if (rx_load) rx_data_q <= bus_rdata_i[7:0];
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign rx_overrun_o = rx_ovr_q;
endmodule

// File: tb/tb_uart_host_ctrl.sv
// Bench for uart_host_ctrl with a bus-level uart_core model and random TX/RX traffic.
module tb_uart_host_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_ovr;
  logic        tx_err;
  logic        busy;
  logic        bus_ren;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        intr;

  uart_host_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .rx_overrun_o(rx_ovr), .tx_err_o(tx_err), .busy_o(busy),
    .bus_ren_o(bus_ren), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata), .intr_tx_i(intr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- uart_core model (bus level) ----------------
  typedef struct { int cyc; logic [7:0] addr; logic [31:0] data; } wr_t;
  wr_t        wlog[$];
  wr_t        w_tmp;
  logic [7:0] sent[$], exp_tx[$], exp_rx[$], rx_got[$], inj_q[$];
  logic [7:0] hold_byte = 8'h00;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_pulse = 1'b0;
  bit         tx_active = 0;
  bit         block_intr = 0;
  bit         inj_en = 0;
  int         tx_cnt = 0;
  int         lat_min = 15;
  int         lat_rng = 0;
  int         intr_cyc = 0;
  int         viol = 0;
  int         cyc = 0;

  initial intr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus_rdata = (bus_addr == 8'd20) ? {31'd0, rx_pulse} :
                     (bus_addr == 8'd8)  ? {24'd0, rx_byte}  : 32'd0;

  always @(negedge clk) begin
    rx_pulse = 1'b0;
    intr     = 1'b0;
    if (rst) begin
      tx_active = 0;
    end else begin
      if (bus_we) begin
        w_tmp.cyc = cyc; w_tmp.addr = bus_addr; w_tmp.data = bus_wdata;
        wlog.push_back(w_tmp);
        if (bus_ren || !(bus_addr == 8'd0 || bus_addr == 8'd4 || bus_addr == 8'd12 || bus_addr == 8'd16))
          viol++;
        if (bus_addr == 8'd4) hold_byte = bus_wdata[7:0];
        if (bus_addr == 8'd16) begin
          if (bus_wdata[0]) begin
            tx_active = 1;
            tx_cnt    = lat_min + $urandom_range(0, lat_rng);
          end else tx_active = 0;
        end
      end else begin
        if (!bus_ren || !(bus_addr == 8'd20 || bus_addr == 8'd8)) viol++;
        if (inj_en && bus_addr == 8'd20 && inj_q.size() > 0 && $urandom_range(0, 3) == 0) begin
          rx_byte  = inj_q.pop_front();
          exp_rx.push_back(rx_byte);
          rx_pulse = 1'b1;
        end
      end
      if (tx_active && !block_intr) begin
        if (tx_cnt == 0) begin
          intr      = 1'b1;
          sent.push_back(hold_byte);
          tx_active = 0;
          intr_cyc  = cyc;
        end else tx_cnt--;
      end
    end
  end

  // Record RX transfers that the next rising edge will complete
  always @(negedge clk) begin
    #2;
    if (!rst && rx_valid && rx_ready) rx_got.push_back(rx_data);
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; holds tx_valid until the FIFO accepts the byte
  task automatic push_byte(input logic [7:0] b);
    bit ok = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    for (int k = 0; k < 3000 && !ok; k++) begin
      #1;
      if (tx_ready) begin ok = 1; exp_tx.push_back(b); end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    if (!ok) chk_eq("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    bit done = 0;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge clk); #1;
      if (!busy && inj_q.size() == 0 && !tx_valid) done = 1;
    end
    if (!done) chk_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_rx_valid(input string tag, input int bound);
    bit done = 0;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge clk); #1;
      if (rx_valid) done = 1;
    end
    if (!done) chk_eq(tag, 32'(rx_valid), 32'd1);
  endtask

  task automatic cmp_tx(input string tag);
    chk_eq({tag, "_count"}, 32'(sent.size()), 32'(exp_tx.size()));
    for (int i = 0; i < sent.size() && i < exp_tx.size(); i++)
      chk_eq(tag, 32'(sent[i]), 32'(exp_tx[i]));
    sent.delete(); exp_tx.delete();
  endtask

  task automatic cmp_rx(input string tag);
    chk_eq({tag, "_count"}, 32'(rx_got.size()), 32'(exp_rx.size()));
    for (int i = 0; i < rx_got.size() && i < exp_rx.size(); i++)
      chk_eq(tag, 32'(rx_got[i]), 32'(exp_rx[i]));
    rx_got.delete(); exp_rx.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
    chk_eq({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk_eq({tag, "_tx_err"},   32'(tx_err),   32'd0);
    chk_eq({tag, "_bus"},      {bus_wdata[23:0], bus_addr} | 32'({bus_we, bus_ren}), 32'd0);
    chk_eq({tag, "_busy"},     32'(busy),     32'd1);
  endtask

  task automatic chk_init_seq(input string tag);
    chk_eq({tag, "_nwr"}, 32'(wlog.size()), 32'd2);
    if (wlog.size() >= 2) begin
      chk_eq({tag, "_w0"}, {wlog[0].data[23:0], wlog[0].addr}, {24'd87, 8'd0});
      chk_eq({tag, "_w1"}, {wlog[1].data[23:0], wlog[1].addr}, {24'd1, 8'd12});
      chk_eq({tag, "_gap"}, 32'(wlog[1].cyc - wlog[0].cyc), 32'd1);
    end
    chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
    chk_eq({tag, "_idle_bus"}, {16'd0, bus_addr, 6'd0, bus_we, bus_ren}, {16'd0, 8'd20, 8'd1});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  s, e;
    bit  acc;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b1;

    // Reset state and init sequence
    tick(3); #1;
    chk_reset_outputs("rst");
    chk_eq("rst_ovr", 32'(rx_ovr), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    wlog.delete();
    tick(4); #1;
    chk_init_seq("init");

    // Single byte TX handshake
    @(negedge clk);
    lat_min = 15; lat_rng = 0;
    wlog.delete();
    push_byte(8'hA5);
    wait_idle("a5_idle", 200);
    chk_eq("a5_nwr", 32'(wlog.size()), 32'd3);
    if (wlog.size() >= 3) begin
      chk_eq("a5_load",  {wlog[0].data[23:0], wlog[0].addr}, {24'hA5, 8'd4});
      chk_eq("a5_start", {wlog[1].data[23:0], wlog[1].addr}, {24'd1, 8'd16});
      chk_eq("a5_stop",  {wlog[2].data[23:0], wlog[2].addr}, {24'd0, 8'd16});
      chk_eq("a5_stop_after_intr", 32'(wlog[2].cyc - intr_cyc), 32'd1);
    end
    cmp_tx("a5_byte");

    // FIFO fills while the first byte is in flight
    @(negedge clk);
    lat_min = 60;
    push_byte(8'h01);
    tick(4);
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_data = 8'h02 + 8'(i);
      #1;
      chk_eq("full_accept", 32'(tx_ready), 32'd1);
      if (tx_ready) exp_tx.push_back(tx_data);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    #1;
    chk_eq("full_ready_low", 32'(tx_ready), 32'd0);
    wait_idle("full_drain", 2000);
    cmp_tx("full_order");

    // RX byte with consumer ready
    @(negedge clk);
    rx_ready = 1'b1; inj_en = 1;
    inj_q.push_back(8'h3C);
    wait_rx_valid("rx3c_valid", 200);
    chk_eq("rx3c_data", 32'(rx_data), 32'h3C);
    @(negedge clk); #1;
    chk_eq("rx3c_clear", 32'(rx_valid), 32'd0);
    chk_eq("rx3c_ovr", 32'(rx_ovr), 32'd0);
    cmp_rx("rx3c_stream");

    // Random mixed TX/RX traffic
    lat_min = 5; lat_rng = 25; acc = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (acc) begin tx_valid = 1'b0; acc = 0; end
      if (!tx_valid && $urandom_range(0, 5) == 0) begin
        tx_valid = 1'b1; tx_data = 8'($urandom);
      end
      if (inj_q.size() < 2 && $urandom_range(0, 29) == 0) inj_q.push_back(8'($urandom));
      #1;
      if (tx_valid && tx_ready) begin exp_tx.push_back(tx_data); acc = 1; end
    end
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle("rand_drain", 5000);
    tick(4);
    cmp_tx("rand_tx");
    cmp_rx("rand_rx");
    chk_eq("rand_ovr", 32'(rx_ovr), 32'd0);

    // Overrun with consumer stalled
    @(negedge clk);
    rx_ready = 1'b0;
    inj_q.push_back(8'h11);
    wait_rx_valid("ovr_first", 200);
    inj_q.push_back(8'h22);
    for (int k = 0; k < 200 && exp_rx.size() < 2; k++) @(negedge clk);
    tick(5); #1;
    chk_eq("ovr_keep", 32'(rx_data), 32'h11);
    chk_eq("ovr_valid", 32'(rx_valid), 32'd1);
    chk_eq("ovr_flag", 32'(rx_ovr), 32'd1);
    chk_eq("ovr_no_xfer", 32'(rx_got.size()), 32'd0);
    @(negedge clk);
    rx_ready = 1'b1;
    tick(3); #1;
    chk_eq("ovr_one_xfer", 32'(rx_got.size()), 32'd1);
    if (rx_got.size() > 0) chk_eq("ovr_xfer_data", 32'(rx_got[0]), 32'h11);
    chk_eq("ovr_drained", 32'(rx_valid), 32'd0);
    rx_got.delete(); exp_rx.delete();

    // TX_WAIT without a done pulse, then reset mid-transfer
    @(negedge clk);
    inj_en = 0; block_intr = 1; lat_min = 10; lat_rng = 0;
    wlog.delete();
`ifdef UART_HOST_TX_TIMEOUT_EN
    push_byte(8'h5A);
    for (int k = 0; k < 1500 && !tx_err; k++) begin @(negedge clk); #1; end
    chk_eq("tmo_err", 32'(tx_err), 32'd1);
    tick(3); #1;
    s = -1; e = -1;
    foreach (wlog[i]) begin
      if (wlog[i].addr == 8'd16 && wlog[i].data[0])  s = wlog[i].cyc;
      if (wlog[i].addr == 8'd16 && !wlog[i].data[0]) e = wlog[i].cyc;
    end
    chk_eq("tmo_wait_len", 32'(e - s), 32'd1201);
    chk_eq("tmo_idle", 32'(busy), 32'd0);
    exp_tx.delete(); sent.delete();
    @(negedge clk);
    push_byte(8'h6B);
    push_byte(8'h7C);
    tick(30); #1;
    chk_eq("tmo_err_sticky", 32'(tx_err), 32'd1);
`else
    push_byte(8'h5A);
    push_byte(8'h6B);
    push_byte(8'h7C);
    tick(1300); #1;
    chk_eq("hang_err", 32'(tx_err), 32'd0);
    s = 0;
    foreach (wlog[i]) if (wlog[i].addr == 8'd16 && !wlog[i].data[0]) s++;
    chk_eq("hang_no_stop", 32'(s), 32'd0);
`endif
    chk_eq("hang_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1;
    chk_reset_outputs("mid_rst");
    tick(2);
    @(posedge clk); #1 rst = 1'b0;
    block_intr = 0;
    wlog.delete(); exp_tx.delete(); sent.delete();
    tick(12); #1;
    chk_init_seq("reinit");
    chk_eq("reinit_ovr", 32'(rx_ovr), 32'd0);
    chk_eq("reinit_err", 32'(tx_err), 32'd0);
    chk_eq("reinit_sent", 32'(sent.size()), 32'd0);

    chk_eq("bus_protocol", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
